// File: rtl/ptp_ts_pkg.sv
// Shared field offsets, widths and FSM encodings for the PTP time-stamp matcher.
package ptp_ts_pkg;

    localparam int TS_MSB    = 111;
    localparam int TS_LSB    = 32;
    localparam int TS_W      = 80;
    localparam int MSGID_MSB = 31;
    localparam int MSGID_LSB = 28;
    localparam int SEQID_MSB = 15;
    localparam int SEQID_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_POP     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic {
        CMD_LOOKUP = 1'b0,
        CMD_FLUSH  = 1'b1
    } cmd_e;

    function automatic logic entry_match(
        input logic [3:0]  entry_msgid,
        input logic [15:0] entry_seqid,
        input logic [3:0]  tgt_msgid,
        input logic [15:0] tgt_seqid,
        input logic        use_msgid
    );
        return (entry_seqid == tgt_seqid) && (!use_msgid || (entry_msgid == tgt_msgid));
    endfunction

endpackage

// File: rtl/ptp_ts_matcher_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins, increment only below the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ptp_ts_matcher.sv
// Pops the time-stamp queue until an entry matches (msgId, seqId), discarding stale entries;
// also flushes the queue on request and keeps saturating hit/miss/drop statistics.
module ptp_ts_matcher
    import ptp_ts_pkg::*;
#(
    parameter int RD_LATENCY  = 1,
    parameter int MAX_POPS    = 16,
    parameter int MATCH_MSGID = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lkp_req_i,
    input  logic [3:0]       lkp_msgid_i,
    input  logic [15:0]      lkp_seqid_i,
    input  logic             flush_req_i,
    output logic             lkp_ready_o,
    output logic             lkp_done_o,
    output logic             lkp_hit_o,
    output logic [TS_W-1:0]  lkp_ts_o,
    output logic [7:0]       lkp_discard_o,
    output logic             q_rd_en_o,
    input  logic [7:0]       q_rd_stat_i,
    input  logic [127:0]     q_rd_data_i,
    output logic [15:0]      stat_hit_o,
    output logic [15:0]      stat_miss_o,
    output logic [15:0]      stat_drop_o
);

    localparam logic [7:0] MAX_POPS_C  = 8'(MAX_POPS);
    localparam logic [1:0] WAIT_LAST_C = 2'(RD_LATENCY - 2);
    localparam logic       USE_MSGID_C = 1'(MATCH_MSGID != 0);

    state_e          state_q, state_d;
    cmd_e            cmd_q, cmd_d;
    logic [3:0]      msgid_q, msgid_d;
    logic [15:0]     seqid_q, seqid_d;
    logic [7:0]      pop_cnt_q, pop_cnt_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            ready_q, done_q, hit_q, rd_en_q;

    logic            hit_s, accept_s, disc_inc_s, hit_inc_s, miss_inc_s, match_s;
    logic            unused_s;

    assign match_s = entry_match(q_rd_data_i[MSGID_MSB:MSGID_LSB], q_rd_data_i[SEQID_MSB:SEQID_LSB],
                                 msgid_q, seqid_q, USE_MSGID_C);

    // Upper pad, checksum and the high nibble of the status word carry nothing we use.
    assign unused_s = ^{q_rd_data_i[127:112], q_rd_data_i[27:16], q_rd_stat_i[7:4]};

    // FSM next state and datapath updates
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        msgid_d    = msgid_q;
        seqid_d    = seqid_q;
        pop_cnt_d  = pop_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ts_d       = ts_q;
        hit_s      = 1'b0;
        accept_s   = 1'b0;
        disc_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    cmd_d    = CMD_FLUSH;
                    accept_s = 1'b1;
                end else if (lkp_req_i) begin
                    cmd_d    = CMD_LOOKUP;
                    msgid_d  = lkp_msgid_i;
                    seqid_d  = lkp_seqid_i;
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
                if (accept_s) begin
                    pop_cnt_d = 8'd0;
                    state_d   = ST_CHECK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (q_rd_stat_i[3:0] == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                pop_cnt_d  = pop_cnt_q + 8'd1;
                wait_cnt_d = 2'd0;
                if (RD_LATENCY > 1) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST_C) begin
                    state_d = ST_COMPARE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_COMPARE: begin
                if ((cmd_q == CMD_LOOKUP) && match_s) begin
                    ts_d    = q_rd_data_i[TS_MSB:TS_LSB];
                    hit_s   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    disc_inc_s = 1'b1;
                    // A flush keeps going until the queue is empty, regardless of MAX_POPS.
                    if ((cmd_q == CMD_LOOKUP) && (pop_cnt_q == MAX_POPS_C)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hit_inc_s  = (state_d == ST_DONE) && (cmd_q == CMD_LOOKUP) && hit_s;
        miss_inc_s = (state_d == ST_DONE) && (cmd_q == CMD_LOOKUP) && !hit_s;
    end

    // State, datapath and registered outputs; outputs decode the next state so they align with it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_LOOKUP;
            msgid_q    <= 4'd0;
            seqid_q    <= 16'd0;
            pop_cnt_q  <= 8'd0;
            wait_cnt_q <= 2'd0;
            ts_q       <= {TS_W{1'b0}};
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            msgid_q    <= msgid_d;
            seqid_q    <= seqid_d;
            pop_cnt_q  <= pop_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ts_q       <= ts_d;
            ready_q    <= (state_d == ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            hit_q      <= (state_d == ST_DONE) && hit_s;
            rd_en_q    <= (state_d == ST_POP);
        end
    end

    sat_cnt #(.W(8)) u_discard (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (accept_s), .inc_i (disc_inc_s), .cnt_o (lkp_discard_o)
    );
    sat_cnt #(.W(16)) u_stat_hit (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (1'b0), .inc_i (hit_inc_s), .cnt_o (stat_hit_o)
    );
    sat_cnt #(.W(16)) u_stat_miss (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (1'b0), .inc_i (miss_inc_s), .cnt_o (stat_miss_o)
    );
    sat_cnt #(.W(16)) u_stat_drop (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (1'b0), .inc_i (disc_inc_s), .cnt_o (stat_drop_o)
    );

    assign lkp_ready_o = ready_q;
    assign lkp_done_o  = done_q;
    assign lkp_hit_o   = hit_q;
    assign lkp_ts_o    = ts_q;
    assign q_rd_en_o   = rd_en_q;

endmodule

// File: tb/tb_ptp_ts_matcher.sv
// Scoreboard bench for ptp_ts_matcher: a queue-level reference model predicts each command's
// outcome at issue time; an independent monitor checks every lkp_done against the prediction.
module tb_ptp_ts_matcher;

    localparam int RD_LAT = 1;
    localparam int MAXP   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         lkp_req, flush_req;
    logic [3:0]   lkp_msgid;
    logic [15:0]  lkp_seqid;
    logic         lkp_ready, lkp_done, lkp_hit, q_rd_en;
    logic [79:0]  lkp_ts;
    logic [7:0]   lkp_discard, q_rd_stat;
    logic [127:0] q_rd_data;
    logic [15:0]  stat_hit, stat_miss, stat_drop;

    always #5 clk = ~clk;

    ptp_ts_matcher #(.RD_LATENCY(RD_LAT), .MAX_POPS(MAXP), .MATCH_MSGID(1)) dut (
        .clk_i (clk), .rst_i (rst), .lkp_req_i (lkp_req), .lkp_msgid_i (lkp_msgid),
        .lkp_seqid_i (lkp_seqid), .flush_req_i (flush_req), .lkp_ready_o (lkp_ready),
        .lkp_done_o (lkp_done), .lkp_hit_o (lkp_hit), .lkp_ts_o (lkp_ts),
        .lkp_discard_o (lkp_discard), .q_rd_en_o (q_rd_en), .q_rd_stat_i (q_rd_stat),
        .q_rd_data_i (q_rd_data), .stat_hit_o (stat_hit), .stat_miss_o (stat_miss),
        .stat_drop_o (stat_drop)
    );

    typedef struct {
        logic        hit;
        logic [79:0] ts;
        logic [7:0]  disc;
        logic [15:0] sh, sm, sd;
        int          pops;
        int          done_cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mq[$];
    int           cyc = 0;
    int           vectors = 0;
    int           miscompares = 0;
    bit           timed_out = 1'b0;

    // model state: statistics and last-hit stamp as the block should report them
    int           m_sh = 0, m_sm = 0, m_sd = 0;
    logic [79:0]  m_ts = 80'd0;
    logic [127:0] pend_d;
    bit           pend_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge; cyc then names that edge.
    initial begin
        int   pops_seen;
        bit   to_reported;
        exp_t e;
        pops_seen   = 0;
        to_reported = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pops_seen = 0;
                chk("reset_ctrl", {lkp_ready, lkp_done, lkp_hit, q_rd_en, lkp_discard},
                    {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
                chk("reset_ts", lkp_ts, 80'd0);
                chk("reset_stats", {stat_hit, stat_miss, stat_drop}, 48'd0);
            end else begin
                if (q_rd_en) begin
                    pops_seen++;
                    chk("no_underflow", {7'd0, q_rd_stat != 8'd0}, 8'd1);
                end
                if (lkp_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("hit", lkp_hit, e.hit);
                        chk("ts", lkp_ts, e.ts);
                        chk("discard", lkp_discard, e.disc);
                        chk("pops", pops_seen, e.pops);
                        chk("stats", {stat_hit, stat_miss, stat_drop}, {e.sh, e.sm, e.sd});
                    end
                    pops_seen = 0;
                end
            end
            if (timed_out && !to_reported) begin
                to_reported = 1'b1;
                chk("timeout", 1'b1, 1'b0);
            end
        end
    end

    // One cycle of the read-queue model: data from a pop appears one cycle after the strobe.
    task automatic step();
        @(negedge clk);
        if (pend_v) q_rd_data = pend_d;
        else        q_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        pend_v = 1'b0;
        if (q_rd_en && (mq.size() > 0)) begin
            pend_d = mq.pop_front();
            pend_v = 1'b1;
        end
        q_rd_stat = 8'(mq.size());
    endtask

    function automatic logic [127:0] mk(input logic [3:0] m, input logic [15:0] s, input logic [79:0] ts);
        logic [15:0] pad;
        logic [11:0] cks;
        pad = 16'($urandom());
        cks = 12'($urandom());
        return {pad, ts, m, cks, s};
    endfunction

    function automatic logic [79:0] rnd_ts();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!lkp_ready && guard < 300) begin step(); guard++; end
        if (guard >= 300) timed_out = 1'b1;
    endtask

    // Predict the outcome from the queue contents, then issue the command and wait for it.
    task automatic run_cmd(input bit fl, input bit lk, input logic [3:0] m, input logic [15:0] s);
        logic [127:0] cp[$];
        logic [127:0] ent;
        exp_t         e;
        int           pops, disc, guard;
        bit           hit, empty_end;
        step();
        wait_ready();
        cp = mq;
        pops = 0; disc = 0; hit = 1'b0; empty_end = 1'b0;
        forever begin
            if (cp.size() == 0) begin empty_end = 1'b1; break; end
            ent = cp.pop_front();
            pops++;
            if (!fl && ent[15:0] == s && ent[31:28] == m) begin
                hit = 1'b1;
                m_ts = ent[111:32];
                break;
            end
            disc++;
            if (!fl && pops == MAXP) break;
        end
        if (!fl && hit)  m_sh++;
        if (!fl && !hit) m_sm++;
        m_sd += disc;
        e.hit  = hit;
        e.ts   = m_ts;
        e.disc = (disc > 255) ? 8'hFF : 8'(disc);
        e.sh   = (m_sh > 65535) ? 16'hFFFF : 16'(m_sh);
        e.sm   = (m_sm > 65535) ? 16'hFFFF : 16'(m_sm);
        e.sd   = (m_sd > 65535) ? 16'hFFFF : 16'(m_sd);
        e.pops = pops;
        // Each pop costs CHECK+POP+COMPARE; an empty-queue CHECK costs one more cycle.
        e.done_cyc = cyc + 1 + 3 * pops + (empty_end ? 1 : 0);
        exp_q.push_back(e);
        flush_req = fl; lkp_req = lk; lkp_msgid = m; lkp_seqid = s;
        step();
        flush_req = 1'b0; lkp_req = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin step(); guard++; end
        if (guard >= 500) timed_out = 1'b1;
    endtask

    initial begin
        int n;
        logic [15:0] base;
        rst = 1'b1; lkp_req = 1'b0; flush_req = 1'b0; lkp_msgid = 4'd0; lkp_seqid = 16'd0;
        q_rd_stat = 8'd0; q_rd_data = 128'd0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // head-of-queue hit
        mq.push_back(mk(4'd0, 16'd5, 80'h1_0000_0000));
        run_cmd(1'b0, 1'b1, 4'd0, 16'd5);
        // two stale entries ahead of the match
        for (int i = 3; i <= 5; i++) mq.push_back(mk(4'd0, 16'(i), rnd_ts()));
        run_cmd(1'b0, 1'b1, 4'd0, 16'd5);
        // msgId mismatch with equal seqId is discarded
        mq.push_back(mk(4'd1, 16'd7, rnd_ts()));
        mq.push_back(mk(4'd0, 16'd7, rnd_ts()));
        run_cmd(1'b0, 1'b1, 4'd0, 16'd7);
        // empty queue miss
        run_cmd(1'b0, 1'b1, 4'd2, 16'd9);
        // pop limit reached before the match; one entry remains
        for (int i = 1; i <= MAXP + 1; i++) mq.push_back(mk(4'd0, 16'(i), rnd_ts()));
        run_cmd(1'b0, 1'b1, 4'd0, 16'(MAXP + 1));
        // flush beats a simultaneous lookup, empties 7 entries
        for (int i = 0; i < 6; i++) mq.push_back(mk(4'd0, 16'd5, rnd_ts()));
        run_cmd(1'b1, 1'b1, 4'd0, 16'd5);

        // reset one cycle after the pop strobe; the popped entry is lost
        mq.push_back(mk(4'd0, 16'd10, rnd_ts()));
        mq.push_back(mk(4'd0, 16'd11, rnd_ts()));
        step();
        wait_ready();
        lkp_req = 1'b1; lkp_msgid = 4'd0; lkp_seqid = 16'd11;
        step();
        lkp_req = 1'b0;
        n = 0;
        while (!q_rd_en && n < 20) begin step(); n++; end
        if (n >= 20) timed_out = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_sh = 0; m_sm = 0; m_sd = 0; m_ts = 80'd0;
        run_cmd(1'b0, 1'b1, 4'd0, 16'd11);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(0, 4);
            base = 16'($urandom_range(0, 7));
            for (int j = 0; j < n; j++)
                if (mq.size() < 15)
                    mq.push_back(mk(4'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), rnd_ts()));
            if ($urandom_range(0, 9) == 0)
                run_cmd(1'b1, 1'($urandom_range(0, 1)), 4'd0, base);
            else
                run_cmd(1'b0, 1'b1, 4'($urandom_range(0, 1)), base);
        end

        repeat (3) step();
        if (exp_q.size() != 0) timed_out = 1'b1;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
